ign_sched: RTL and testbench

IGN_SCHED -- requirements
Module: ign_sched

---
 rtl/ign_sched.sv | 123 ++++++++++++
 tb/tb_ign_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ign_sched.sv
// Angle-based ignition scheduler: on each tooth trigger, sweeps the cylinders one per
// clock through a single shared multiplier and arms a per-channel spark countdown.
module ign_sched #(
  parameter int NCYL         = 4,
  parameter int CYCLE_QUANTA = 15360,
  parameter int LEAD         = 20,
  parameter int COMP         = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic [15:0]          eng_phase,
  input  logic [15:0]          next_tooth_width,
  input  logic [31:0]          tooth_period,
  input  logic [NCYL*16-1:0]   timing,
  input  logic [NCYL-1:0]      enable,
  output logic [NCYL-1:0]      spark,
  output logic [NCYL-1:0]      armed,
  output logic                 busy,
  output logic                 overrun
);

  localparam int IW = (NCYL > 1) ? $clog2(NCYL) : 1;

  typedef enum logic {IDLE, EVAL} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [15:0]   phase_q;
  logic [15:0]   ntw_q;
  logic [31:0]   period_q;
  logic [31:0]   count [NCYL];

  logic [15:0]        tim_sel;
  logic signed [16:0] q_raw;
  logic [16:0]        q;
  logic               in_range;
  logic               in_window;
  logic [47:0]        prod;
  logic [31:0]        r_sat;
  logic [32:0]        dec;
  logic [31:0]        load;
  logic               arm_now;
  logic               last;

  assign last = (idx == IW'(NCYL - 1));
  assign busy = (state == EVAL);

  // Evaluation datapath for the cylinder selected by idx; the one multiplier is shared.
  assign tim_sel   = timing[16*idx +: 16];
  assign q_raw     = $signed({1'b0, tim_sel}) - $signed({1'b0, phase_q});
  assign q         = q_raw[16] ? (17'(q_raw) + 17'(CYCLE_QUANTA)) : 17'(q_raw);
  assign in_range  = (32'(tim_sel) < 32'(CYCLE_QUANTA));
  assign in_window = (q <= ({1'b0, ntw_q} + 17'(LEAD)));
  assign prod      = 48'(period_q) * 48'(q);
  assign r_sat     = (|prod[47:40]) ? 32'hFFFF_FFFF : prod[39:8];
  assign dec       = 33'(COMP) + 33'(idx);
  assign load      = ({1'b0, r_sat} > dec) ? (r_sat - dec[31:0]) : 32'd0;
  assign arm_now   = busy && enable[idx] && !armed[idx] && in_range &&
                     (q != 17'd0) && in_window;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (trigger) state_nx = EVAL;
      EVAL:    if (last)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sweep bookkeeping; operands are frozen at the accepted trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      phase_q  <= '0;
      ntw_q    <= '0;
      period_q <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= busy && trigger;
      if (state == IDLE && trigger) begin
        idx      <= '0;
        phase_q  <= eng_phase;
        ntw_q    <= next_tooth_width;
        period_q <= tooth_period;
      end else if (busy) begin
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end

  // Channel countdowns: a disable aborts, otherwise zero fires the spark and disarms.
  always_ff @(posedge clk) begin
    if (reset) begin
      spark <= '0;
      armed <= '0;
      for (int c = 0; c < NCYL; c++) count[c] <= '0;
    end else begin
      for (int c = 0; c < NCYL; c++) begin
        spark[c] <= 1'b0;
        if (armed[c]) begin
          if (!enable[c]) begin
            armed[c] <= 1'b0;
          end else if (count[c] == 32'd0) begin
            spark[c] <= 1'b1;
            armed[c] <= 1'b0;
          end else begin
            count[c] <= count[c] - 32'd1;
          end
        end else if (arm_now && (idx == IW'(c))) begin
          count[c] <= load;
          armed[c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ign_sched.sv
// Bench for ign_sched: directed cases plus random sweeps checked every cycle against an
// event-time model (predicted arm/spark cycles per channel).
module tb_ign_sched;

  localparam int NCYL = 4;
  localparam int CQ   = 15360;
  localparam int LEAD = 20;
  localparam int COMP = 6;

  logic                clk;
  logic                reset;
  logic                trigger;
  logic [15:0]         eng_phase;
  logic [15:0]         next_tooth_width;
  logic [31:0]         tooth_period;
  logic [NCYL*16-1:0]  timing;
  logic [NCYL-1:0]     enable;
  logic [NCYL-1:0]     spark;
  logic [NCYL-1:0]     armed;
  logic                busy;
  logic                overrun;

  ign_sched #(.NCYL(NCYL), .CYCLE_QUANTA(CQ), .LEAD(LEAD), .COMP(COMP)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .eng_phase(eng_phase),
    .next_tooth_width(next_tooth_width), .tooth_period(tooth_period),
    .timing(timing), .enable(enable), .spark(spark), .armed(armed),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: per channel the armed interval [arm_from, arm_until) and the spark cycle.
  longint arm_from [NCYL];
  longint arm_until[NCYL];
  longint spark_at [NCYL];
  longint busy_from, busy_until, overrun_at;
  longint last_spark[NCYL];
  int     spark_cnt [NCYL];
  longint last_ov;
  int     ov_cnt;
  int     compared, mismatched;
  bit     check_en;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [NCYL-1:0] expArmed(longint t);
    logic [NCYL-1:0] r;
    for (int c = 0; c < NCYL; c++) r[c] = (arm_from[c] >= 0) && (t >= arm_from[c]) && (t < arm_until[c]);
    return r;
  endfunction

  function automatic logic [NCYL-1:0] expSpark(longint t);
    logic [NCYL-1:0] r;
    for (int c = 0; c < NCYL; c++) r[c] = (t == spark_at[c]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("spark", 64'(spark), 64'(expSpark(cyc)));
      checkOutput("armed", 64'(armed), 64'(expArmed(cyc)));
      checkOutput("busy", 64'(busy), 64'((cyc >= busy_from) && (cyc <= busy_until)));
      checkOutput("overrun", 64'(overrun), 64'(cyc == overrun_at));
      for (int c = 0; c < NCYL; c++) if (spark[c] === 1'b1) begin
        last_spark[c] = cyc;
        spark_cnt[c]++;
      end
      if (overrun === 1'b1) begin
        last_ov = cyc;
        ov_cnt++;
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Lowering an enable bit aborts that channel's pending spark from the next cycle.
  task automatic setEnable(input logic [NCYL-1:0] en);
    longint td = cyc;
    for (int c = 0; c < NCYL; c++) begin
      if (enable[c] && !en[c] && arm_from[c] >= 0 && td >= arm_from[c] && td < arm_until[c]) begin
        arm_until[c] = td + 1;
        if (spark_at[c] > td) spark_at[c] = -1;
      end
    end
    enable = en;
  endtask

  task automatic applyStimulus(input int phase, input int ntw, input longint period,
                               input logic [NCYL*16-1:0] tim, input logic [NCYL-1:0] en);
    eng_phase        = 16'(phase);
    next_tooth_width = 16'(ntw);
    tooth_period     = 32'(period);
    timing           = tim;
    setEnable(en);
  endtask

  // Trigger for one cycle; an accepted trigger predicts each cylinder's arm and spark cycle.
  task automatic fireTrigger();
    longint t0 = cyc;
    trigger = 1'b1;
    if (t0 >= busy_from && t0 <= busy_until) begin
      overrun_at = t0 + 1;
    end else begin
      busy_from  = t0 + 1;
      busy_until = t0 + NCYL;
      for (int i = 0; i < NCYL; i++) begin
        longint ev = t0 + 1 + i;
        longint tm = longint'(timing[16*i +: 16]);
        longint q  = tm - longint'(eng_phase);
        bit was_armed;
        if (q < 0) q = q + CQ;
        was_armed = (arm_from[i] >= 0) && (ev >= arm_from[i]) && (ev < arm_until[i]);
        if (enable[i] && !was_armed && tm < CQ && q != 0 && q <= longint'(next_tooth_width) + LEAD) begin
          longint r = (longint'(tooth_period) * q) >>> 8;
          longint d;
          if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
          d = r - COMP - i;
          if (d < 0) d = 0;
          arm_from[i]  = ev + 1;
          spark_at[i]  = ev + 2 + d;
          arm_until[i] = spark_at[i];
        end
      end
    end
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic applyReset();
    longint tr = cyc;
    reset = 1'b1;
    for (int c = 0; c < NCYL; c++) begin
      if (arm_until[c] > tr + 1) arm_until[c] = tr + 1;
      if (spark_at[c] > tr) spark_at[c] = -1;
    end
    if (busy_until > tr) busy_until = tr;
    if (overrun_at > tr) overrun_at = -1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [NCYL*16-1:0] oneTiming(input int ch, input int val);
    logic [NCYL*16-1:0] v = '0;
    v[16*ch +: 16] = 16'(val);
    return v;
  endfunction

  task automatic drainModel();
    longint mx = cyc;
    for (int c = 0; c < NCYL; c++) if (spark_at[c] > mx) mx = spark_at[c];
    while (cyc <= mx + 2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    longint t0;
    int     cnt0;
    logic [NCYL*16-1:0] tv;
    compared = 0; mismatched = 0; check_en = 0;
    for (int c = 0; c < NCYL; c++) begin
      arm_from[c] = -1; arm_until[c] = -1; spark_at[c] = -1;
      last_spark[c] = -1; spark_cnt[c] = 0;
    end
    busy_from = -1; busy_until = -2; overrun_at = -1; last_ov = -1; ov_cnt = 0;
    reset = 1'b1; trigger = 1'b0; eng_phase = '0; next_tooth_width = '0;
    tooth_period = '0; timing = '0; enable = '0;
    waitCycles(2);
    check_en = 1;
    checkOutput("reset_outputs", 64'({spark, armed, busy, overrun}), 64'd0);
    waitCycles(1);
    reset = 1'b0;
    waitCycles(2);

    // Basic case
    applyStimulus(0, 100, 256, oneTiming(0, 100), 4'b0001);
    t0 = cyc; fireTrigger();
    checkOutput("basic_armed_t0p1", 64'(armed[0]), 64'd0);
    waitCycles(1);
    checkOutput("basic_armed_t0p2", 64'(armed[0]), 64'd1);
    waitCycles(105);
    checkOutput("basic_spark_time", 64'(last_spark[0]), 64'(t0 + 97));
    checkOutput("basic_spark_count", 64'(spark_cnt[0]), 64'd1);

    // Wrap case
    applyStimulus(15300, 100, 512, oneTiming(1, 50), 4'b0010);
    t0 = cyc; fireTrigger();
    waitCycles(225);
    checkOutput("wrap_spark_time", 64'(last_spark[1]), 64'(t0 + 217));

    // Bounds: none of these may arm
    cnt0 = spark_cnt[0];
    applyStimulus(500, 100, 256, oneTiming(0, 500), 4'b0001);
    fireTrigger(); waitCycles(3);
    checkOutput("bound_q0_armed", 64'(armed), 64'd0);
    applyStimulus(0, 100, 256, oneTiming(0, 121), 4'b0001);
    fireTrigger(); waitCycles(3);
    checkOutput("bound_q121_armed", 64'(armed), 64'd0);
    applyStimulus(0, 100, 256, oneTiming(0, 15360), 4'b0001);
    fireTrigger(); waitCycles(3);
    checkOutput("bound_timing_cq_armed", 64'(armed), 64'd0);
    applyStimulus(0, 100, 256, oneTiming(0, 100), 4'b0000);
    fireTrigger(); waitCycles(120);
    checkOutput("bound_enable0_sparks", 64'(spark_cnt[0]), 64'(cnt0));
    applyStimulus(0, 100, 256, oneTiming(0, 120), 4'b0001);
    t0 = cyc; fireTrigger(); waitCycles(125);
    checkOutput("bound_q120_spark_time", 64'(last_spark[0]), 64'(t0 + 117));

    // Overrun
    applyStimulus(0, 100, 256, '0, 4'b0000);
    cnt0 = ov_cnt;
    t0 = cyc; fireTrigger(); waitCycles(1); fireTrigger(); waitCycles(6);
    checkOutput("overrun_count", 64'(ov_cnt - cnt0), 64'd1);
    checkOutput("overrun_time", 64'(last_ov), 64'(t0 + 3));

    // Saturation to zero, then simultaneous sparks
    applyStimulus(0, 100, 256, oneTiming(3, 2), 4'b1000);
    t0 = cyc; fireTrigger(); waitCycles(8);
    checkOutput("sat_spark3_time", 64'(last_spark[3]), 64'(t0 + 6));
    applyStimulus(0, 100, 256, {4{16'd50}}, 4'b1111);
    t0 = cyc; fireTrigger(); waitCycles(50);
    for (int c = 0; c < NCYL; c++) checkOutput($sformatf("equal_r_spark%0d", c), 64'(last_spark[c]), 64'(t0 + 47));

    // No reload of a running channel
    applyStimulus(0, 100, 256, oneTiming(0, 100), 4'b0001);
    t0 = cyc; fireTrigger(); waitCycles(19);
    eng_phase = 16'd50;
    fireTrigger(); waitCycles(90);
    checkOutput("noreload_spark_time", 64'(last_spark[0]), 64'(t0 + 97));

    // Enable drop abort
    applyStimulus(0, 100, 256, oneTiming(0, 100), 4'b0001);
    cnt0 = spark_cnt[0];
    t0 = cyc; fireTrigger(); waitCycles(49);
    setEnable(4'b0000);
    waitCycles(1);
    checkOutput("drop_armed_t0p51", 64'(armed[0]), 64'd0);
    waitCycles(60);
    checkOutput("drop_no_spark", 64'(spark_cnt[0]), 64'(cnt0));

    // Reset abort with all channels pending
    applyStimulus(0, 100, 256, {4{16'd100}}, 4'b1111);
    cnt0 = spark_cnt[0] + spark_cnt[1] + spark_cnt[2] + spark_cnt[3];
    fireTrigger(); waitCycles(49);
    applyReset();
    checkOutput("reset_abort_outputs", 64'({spark, armed, busy, overrun}), 64'd0);
    waitCycles(70);
    checkOutput("reset_abort_no_spark", 64'(spark_cnt[0] + spark_cnt[1] + spark_cnt[2] + spark_cnt[3]), 64'(cnt0));

    // Randomized sweeps, overlapping triggers, enable drops and resets
    for (int n = 0; n < 40; n++) begin
      int ph = $urandom_range(0, CQ - 1);
      for (int c = 0; c < NCYL; c++) begin
        int off = int'($urandom_range(0, 140)) - 5;
        int tm  = (ph + off + CQ) % CQ;
        if ($urandom_range(0, 9) == 0) tm = CQ + int'($urandom_range(0, 100));
        tv[16*c +: 16] = 16'(tm);
      end
      applyStimulus(ph, $urandom_range(0, 150), $urandom_range(1, 512), tv, 4'($urandom_range(0, 15)));
      fireTrigger();
      waitCycles($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) begin
        eng_phase = 16'((ph + int'($urandom_range(0, 60))) % CQ);
        fireTrigger();
      end
      waitCycles($urandom_range(4, 30));
      case ($urandom_range(0, 5))
        0: applyReset();
        1: setEnable(enable & 4'($urandom_range(0, 15)));
        default: ;
      endcase
      drainModel();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
